// File: rtl/decrypted_msg_checker.sv
// Scans the decrypted-message RAM after a start pulse and reports whether every
// byte is a lowercase letter or space, stopping at the first illegal byte.
module decrypted_msg_checker #(
    parameter int unsigned MSG_LEN = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              start_i,
    output logic [ADDR_W-1:0] msg_address_o,
    output logic              msg_wren_o,
    input  logic [7:0]        msg_q_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              valid_flag_o,
    output logic [ADDR_W-1:0] bad_index_o,
    output logic [7:0]        bad_char_o
);

    typedef enum logic [2:0] {StIdle, StRead, StWait, StCheck, StDone} state_e;

    localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(MSG_LEN - 1);
    localparam bit                HasWait  = (RD_LAT > 1);
    localparam logic [7:0]        WaitLast = 8'((RD_LAT > 1) ? RD_LAT - 2 : 0);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]        wait_q, wait_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] bad_index_q, bad_index_d;
    logic [7:0]        bad_char_q, bad_char_d;
    logic              byte_ok;

    assign byte_ok = (msg_q_i == 8'h20) || ((msg_q_i >= 8'h61) && (msg_q_i <= 8'h7A));

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            wait_q      <= '0;
            valid_q     <= 1'b0;
            bad_index_q <= '0;
            bad_char_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wait_q      <= wait_d;
            valid_q     <= valid_d;
            bad_index_q <= bad_index_d;
            bad_char_q  <= bad_char_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wait_d      = wait_q;
        valid_d     = valid_q;
        bad_index_d = bad_index_q;
        bad_char_d  = bad_char_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d     = StRead;
                    idx_d       = '0;
                    valid_d     = 1'b0;
                    bad_index_d = '0;
                    bad_char_d  = '0;
                end
            end
            StRead: begin
                wait_d  = '0;
                state_d = HasWait ? StWait : StCheck;
            end
            // Address is held here until the RAM data has caught up.
            StWait: begin
                if (wait_q == WaitLast) begin
                    state_d = StCheck;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StCheck: begin
                if (!byte_ok) begin
                    bad_index_d = idx_q;
                    bad_char_d  = msg_q_i;
                    valid_d     = 1'b0;
                    state_d     = StDone;
                end else if (idx_q == LastIdx) begin
                    valid_d = 1'b1;
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StRead;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        unique case (state_q)
            StRead, StWait, StCheck: busy_o = 1'b1;
            StDone:                  done_o = 1'b1;
            default:                 ;
        endcase
    end

    assign msg_address_o = idx_q;
    assign msg_wren_o    = 1'b0;
    assign valid_flag_o  = valid_q;
    assign bad_index_o   = bad_index_q;
    assign bad_char_o    = bad_char_q;

endmodule

// File: tb/tb_decrypted_msg_checker.sv
// Bench for decrypted_msg_checker: one instance at RD_LAT=1, one at RD_LAT=2,
// each fed from its own RAM model, checked against a first-illegal-byte model.
module tb_decrypted_msg_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start0, start1;
    logic [4:0] addr0, addr1, bidx0, bidx1;
    logic       wren0, wren1, busy0, busy1, done0, done1, valid0, valid1;
    logic [7:0] q0, q1, p1, bchr0, bchr1;
    logic [7:0] mem0 [32];
    logic [7:0] mem1 [32];

    int checks = 0;
    int errors = 0;
    int tsel   = 0;

    logic       o_busy, o_done, o_valid, o_wren;
    logic [4:0] o_addr, o_bidx;
    logic [7:0] o_bchr;

    always @(posedge clk) begin
        q0 <= mem0[addr0];
        p1 <= mem1[addr1];
        q1 <= p1;
    end

    always_comb begin
        o_busy  = (tsel != 0) ? busy1  : busy0;
        o_done  = (tsel != 0) ? done1  : done0;
        o_valid = (tsel != 0) ? valid1 : valid0;
        o_wren  = (tsel != 0) ? wren1  : wren0;
        o_addr  = (tsel != 0) ? addr1  : addr0;
        o_bidx  = (tsel != 0) ? bidx1  : bidx0;
        o_bchr  = (tsel != 0) ? bchr1  : bchr0;
    end

    decrypted_msg_checker #(.MSG_LEN(32), .ADDR_W(5), .RD_LAT(1)) u_dut0 (
        .clk_i(clk), .reset_ni(rst_n), .start_i(start0), .msg_address_o(addr0),
        .msg_wren_o(wren0), .msg_q_i(q0), .busy_o(busy0), .done_o(done0),
        .valid_flag_o(valid0), .bad_index_o(bidx0), .bad_char_o(bchr0)
    );

    decrypted_msg_checker #(.MSG_LEN(32), .ADDR_W(5), .RD_LAT(2)) u_dut1 (
        .clk_i(clk), .reset_ni(rst_n), .start_i(start1), .msg_address_o(addr1),
        .msg_wren_o(wren1), .msg_q_i(q1), .busy_o(busy1), .done_o(done1),
        .valid_flag_o(valid1), .bad_index_o(bidx1), .bad_char_o(bchr1)
    );

    function automatic bit legal(input logic [7:0] v);
        return (v == 8'd32) || (v >= 8'd97 && v <= 8'd122);
    endfunction

    function automatic logic [7:0] rand_legal();
        int r = $urandom_range(0, 26);
        return (r == 26) ? 8'd32 : 8'(8'd97 + r);
    endfunction

    function automatic logic [7:0] rand_illegal();
        logic [7:0] v = 8'($urandom_range(0, 255));
        while (legal(v)) v = 8'($urandom_range(0, 255));
        return v;
    endfunction

    task automatic set_byte(input int sel, input int i, input logic [7:0] v);
        if (sel != 0) mem1[i] = v;
        else          mem0[i] = v;
    endtask

    task automatic get_byte(input int sel, input int i, output logic [7:0] v);
        v = (sel != 0) ? mem1[i] : mem0[i];
    endtask

    task automatic load_alpha(input int sel);
        string s = "abcdefghijklmnopqrstuvwxyz abcde";
        for (int i = 0; i < 32; i++) set_byte(sel, i, s[i]);
    endtask

    // Scans the message as the spec describes: first illegal byte wins.
    task automatic model(input int sel, output int cyc, output bit vld,
                         output int idx, output logic [7:0] chr);
        int lat = (sel != 0) ? 2 : 1;
        int k = 31;
        logic [7:0] v;
        vld = 1'b1;
        idx = 0;
        chr = 8'd0;
        for (int i = 0; i < 32; i++) begin
            get_byte(sel, i, v);
            if (vld && !legal(v)) begin
                vld = 1'b0;
                idx = i;
                chr = v;
                k   = i;
            end
        end
        cyc = (lat + 1) * k + lat + 2;
    endtask

    task automatic pulse_start(input int sel);
        @(negedge clk);
        if (sel != 0) start1 = 1'b1;
        else          start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic run_scan(input int sel, input string name);
        int exp_cyc, exp_idx, cyc, busy_err, addr_err, max_addr, prev;
        bit exp_vld, clr_err;
        logic [7:0] exp_chr;
        tsel = sel;
        model(sel, exp_cyc, exp_vld, exp_idx, exp_chr);
        pulse_start(sel);
        cyc = 1; busy_err = 0; addr_err = 0; max_addr = 0; prev = 0;
        clr_err = (o_valid !== 1'b0) || (o_bidx !== 5'd0) || (o_bchr !== 8'd0);
        while (o_done !== 1'b1 && cyc < 300) begin
            if (o_busy !== 1'b1) busy_err++;
            if (o_addr < prev || int'(o_addr) > prev + 1) addr_err++;
            prev = o_addr;
            if (int'(o_addr) > max_addr) max_addr = o_addr;
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (cyc !== exp_cyc) begin
            errors++;
            $display("FAIL %s done_cycle got %0d want %0d", name, cyc, exp_cyc);
        end
        checks++;
        if (clr_err) begin
            errors++;
            $display("FAIL %s results_cleared_on_start got 1 want 0", name);
        end
        checks++;
        if (busy_err != 0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy got %0d bad cycles busy_at_done=%b want 0/0",
                     name, busy_err, o_busy);
        end
        checks++;
        if (addr_err != 0 || max_addr != (exp_vld ? 31 : exp_idx)) begin
            errors++;
            $display("FAIL %s addr_seq got err=%0d max=%0d want 0/%0d", name, addr_err,
                     max_addr, exp_vld ? 31 : exp_idx);
        end
        checks++;
        if (o_valid !== exp_vld || o_bidx !== 5'(exp_idx) || o_bchr !== exp_chr) begin
            errors++;
            $display("FAIL %s result got v=%b i=%0d c=%h want v=%b i=%0d c=%h", name,
                     o_valid, o_bidx, o_bchr, exp_vld, exp_idx, exp_chr);
        end
        checks++;
        if (o_wren !== 1'b0) begin
            errors++;
            $display("FAIL %s wren got %b want 0", name, o_wren);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_valid !== exp_vld ||
            o_bidx !== 5'(exp_idx) || o_bchr !== exp_chr) begin
            errors++;
            $display("FAIL %s hold got d=%b b=%b v=%b i=%0d c=%h want 0 0 %b %0d %h", name,
                     o_done, o_busy, o_valid, o_bidx, o_bchr, exp_vld, exp_idx, exp_chr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start0 = i[0];
            start1 = ~i[0];
            @(posedge clk);
            #1;
            checks++;
            if ({busy0, done0, valid0, addr0, bidx0, bchr0, busy1, done1, valid1, addr1,
                 bidx1, bchr1, wren0, wren1} !== '0) begin
                errors++;
                $display("FAIL reset_outputs got nonzero want all 0 (cycle %0d)", i);
            end
        end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        rst_n  = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || addr0 !== 5'd0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got busy=%b done=%b addr=%0d want 0 0 0",
                     busy0, done0, addr0);
        end
    endtask

    task automatic test_alpha();
        load_alpha(0);
        run_scan(0, "alpha_valid");
        set_byte(0, 7, 8'h41);
        run_scan(0, "alpha_bad7");
    endtask

    task automatic test_boundaries();
        logic [7:0] bad [3];
        logic [7:0] good [3];
        bad[0] = 8'h60; bad[1] = 8'h7B; bad[2] = 8'h1F;
        good[0] = 8'h61; good[1] = 8'h7A; good[2] = 8'h20;
        load_alpha(0);
        for (int b = 0; b < 3; b++) begin
            set_byte(0, 0, bad[b]);
            run_scan(0, "edge_bad0");
        end
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 32; i++) set_byte(0, i, good[g]);
            run_scan(0, "edge_good");
        end
    endtask

    task automatic test_start_ignored_and_reset();
        int cyc;
        tsel = 0;
        load_alpha(0);
        pulse_start(0);
        cyc = 1;
        while (done0 !== 1'b1 && cyc < 300) begin
            start0 = (cyc == 20);
            @(posedge clk);
            #1;
            cyc++;
        end
        start0 = 1'b0;
        checks++;
        if (cyc != 65) begin
            errors++;
            $display("FAIL restart_ignored done_cycle got %0d want 65", cyc);
        end
        repeat (2) @(posedge clk);
        pulse_start(0);
        for (int c = 1; c < 21; c++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || addr0 !== 5'd0 || valid0 !== 1'b0) begin
            errors++;
            $display("FAIL midscan_reset got busy=%b done=%b addr=%0d want 0 0 0",
                     busy0, done0, addr0);
        end
        cyc = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done0 !== 1'b0 || busy0 !== 1'b0) cyc++;
        end
        checks++;
        if (cyc != 0) begin
            errors++;
            $display("FAIL midscan_reset_quiet got %0d active cycles want 0", cyc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_scan(0, "restart_after_reset");
    endtask

    task automatic test_rdlat2();
        load_alpha(1);
        run_scan(1, "lat2_valid");
        set_byte(1, 12, 8'h2E);
        run_scan(1, "lat2_fail");
        set_byte(1, 12, 8'h6D);
        run_scan(1, "lat2_pass_after_fail");
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            int sel = $urandom_range(0, 1);
            for (int i = 0; i < 32; i++) set_byte(sel, i, rand_legal());
            if ($urandom_range(0, 2) != 0) begin
                set_byte(sel, $urandom_range(0, 31), rand_illegal());
                if ($urandom_range(0, 1) != 0) set_byte(sel, $urandom_range(0, 31),
                                                        rand_illegal());
            end
            run_scan(sel, "random");
        end
    endtask

    initial begin
        start0 = 1'b0;
        start1 = 1'b0;
        rst_n  = 1'b0;
        for (int i = 0; i < 32; i++) begin
            mem0[i] = 8'h61;
            mem1[i] = 8'h61;
        end
        test_reset();
        test_alpha();
        test_boundaries();
        test_start_ignored_and_reset();
        test_rdlat2();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
